matrix_loader: RTL and testbench
================================

Name: matrix_loader

Overview:
- Writer side of the 5x10 augmented-matrix RAM that the Gauss-Jordan inverter reads.
- Accepts the N*N coefficient matrix as a valid/ready word stream in row-major order.
- Writes the augmented matrix [A | I] row-major into the single-port RAM: stream words go to columns 0..N-1; identity words are generated internally for columns N..2N-1.
- Pulses done when the RAM image is complete, so the inverter can be started.

Parameters:
- N, 5, matrix order; the row stride in RAM is 2N.
- DATA_W, 32, RAM word width.
- ADDR_W, 6, RAM address width; 2^ADDR_W must be >= BASE_ADDR + 2*N*N.
- BASE_ADDR, 1, RAM address of element [0][0].
- ONE_VAL, 32'd1, word written on the identity diagonal; all other identity words are 0.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a load; honoured only in IDLE
- in_valid  input  1  stream word valid
- in_ready  output  1  loader accepts a stream word this cycle
- in_data  input  DATA_W  coefficient A[r][c], row-major
- ram_we  output  1  RAM write enable
- ram_addr  output  ADDR_W  RAM address
- ram_din  output  DATA_W  RAM write data
- busy  output  1  high from the cycle after start until done
- done  output  1  one-cycle pulse after the final RAM write
- err  output  1  zero-diagonal flag (see Optional Feature)

Behaviour:
- Reset (asynchronous) clears: state=IDLE, in_ready=0, ram_we=0, ram_addr=BASE_ADDR, ram_din=0, busy=0, done=0, err=0, row=0, col=0.
- Reset mid-load aborts immediately. Words already written stay in the RAM. No done pulse is issued.
- States:
  - IDLE: start=1 -> LOAD_A, row=0, col=0, busy=1.
  - LOAD_A: in_ready=1. On each handshake (in_valid & in_ready), register ram_we=1, ram_addr=BASE_ADDR+row*2N+col, ram_din=in_data, then col++. When col==N-1 is accepted -> GEN_I.
  - GEN_I: in_ready=0. Each cycle write one identity word, ram_din = (col-N==row) ? ONE_VAL : 0, then col++. When col==2N-1 is written: col=0, row++; if row was N-1 -> FIN, else -> LOAD_A.
  - FIN: ram_we=0, done=1 for one cycle, busy=0 -> IDLE.
- Write latency: ram_we/ram_addr/ram_din are registered and appear the cycle after the handshake or identity-generation cycle.
- ram_we is 0 in every cycle that has no handshake or identity generation.
- Address generation uses an incrementing running counter, not a multiply. The address advances by exactly 1 per write and never skips.
- Total writes per load = 2*N*N (50). The last address is BASE_ADDR+2N*N-1 (50).
- in_valid low in LOAD_A stalls the load with no write. GEN_I never stalls.
- start asserted while busy is ignored. start coinciding with done (FIN cycle) is ignored.
- in_data presented outside LOAD_A is not consumed.

Optional Feature:
- Macro: MATRIX_LOADER_ZERO_PIVOT_CHK_EN.
- Defined: when an accepted word has col==row and in_data==0, err is set. err is sticky until the next accepted start or reset. The load still completes normally.
- Undefined: err is tied to 0 and no comparator is built.

Decomposition:
- Package matrix_pkg:
  - MAT_N, MAT_DATA_W, MAT_ADDR_W, MAT_BASE_ADDR, MAT_ONE constants, shared with the inverter.
  - State enum {IDLE, LOAD_A, GEN_I, FIN}.
  - Row-stride constant 2*MAT_N.
- Sub-module matrix_index_counter: row/col counters with the N and 2N wrap points, the running RAM address, and last-column/last-row flags.

Test Plan:
- Reset then start, stream 1..25 with in_valid held high -> 50 writes at addr 1..50. Row 0 is 1,2,3,4,5,1,0,0,0,0. Row 4 is 21..25,0,0,0,0,1. done pulses exactly one cycle after the write to addr 50.
- Same stream with in_valid toggled 1/0 every cycle -> identical RAM image, no writes while stalled, in_ready=0 during all GEN_I cycles.
- start pulsed again at the 10th write -> ignored; exactly 50 writes; a single done pulse.
- rst asserted at the 23rd write -> ram_we drops in the same cycle, state IDLE, no done. A new start then performs a full 50-write load from addr 1.
- Macro defined, A[2][2]=0 -> err rises the cycle after that word is accepted, stays high through done, and clears on the next start. Macro undefined, same stimulus -> err stays 0.
- BASE_ADDR=10, ONE_VAL=32'h3F800000 -> writes at addr 10..59. Diagonal identity words are 3F800000 at addr 15, 26, 37, 48, 59.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: constants shared between the augmented-matrix loader and the
// Gauss-Jordan inverter, the loader state encoding, and an index-width helper.
package matrix_pkg;

    localparam int MAT_N         = 5;
    localparam int MAT_DATA_W    = 32;
    localparam int MAT_ADDR_W    = 6;
    localparam int MAT_BASE_ADDR = 1;
    localparam logic [MAT_DATA_W-1:0] MAT_ONE = 32'd1;

    // Row stride of the augmented matrix [A | I] in RAM.
    localparam int MAT_STRIDE = 2 * MAT_N;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        GEN_I  = 2'd2,
        FIN    = 2'd3
    } state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// matrix_loader_if: coefficient stream (valid/ready) plus the single-port
// RAM write port of the matrix loader.
//   in_valid/in_ready/in_data : row-major A[r][c] word stream
//   ram_we/ram_addr/ram_din   : registered RAM write port
// Modports: master = stream source / RAM side, slave = the loader.
interface matrix_loader_if
    import matrix_pkg::*;
#(
    parameter int DATA_W = MAT_DATA_W,
    parameter int ADDR_W = MAT_ADDR_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;

    modport master (
        output in_valid, in_data,
        input  in_ready, ram_we, ram_addr, ram_din
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ram_we, ram_addr, ram_din
    );

endinterface

// File: rtl/matrix_index_counter.sv
// matrix_index_counter: row/col position inside the augmented matrix and the
// running RAM address of the next write.
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : restart at [0][0] / BASE_ADDR
//   advance      : one element written; step col (wrap at 2N) and address
//   row, col     : current element position
//   addr         : RAM address of the current element
//   last_a_col   : col == N-1 (last coefficient column)
//   last_col     : col == 2N-1 (last identity column)
//   last_row     : row == N-1
module matrix_index_counter
    import matrix_pkg::*;
#(
    parameter int N         = MAT_N,
    parameter int ADDR_W    = MAT_ADDR_W,
    parameter int BASE_ADDR = MAT_BASE_ADDR,
    localparam int ROW_W    = idx_w(N),
    localparam int COL_W    = idx_w(2 * N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] addr,
    output logic              last_a_col,
    output logic              last_col,
    output logic              last_row
);

    assign last_a_col = (col == COL_W'(N - 1));
    assign last_col   = (col == COL_W'(2 * N - 1));
    assign last_row   = (row == ROW_W'(N - 1));

    // The address is a free-running increment: the layout is dense row-major
    // with stride 2N, so every write lands exactly one word after the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row  <= '0;
            col  <= '0;
            addr <= ADDR_W'(BASE_ADDR);
        end else if (clear) begin
            row  <= '0;
            col  <= '0;
            addr <= ADDR_W'(BASE_ADDR);
        end else if (advance) begin
            addr <= addr + 1'b1;
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: writes the augmented matrix [A | I] row-major into the
// inverter's RAM. Columns 0..N-1 come from the coefficient stream, columns
// N..2N-1 are generated identity words. done pulses once the image is complete.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin a load (taken only in IDLE, not in the done cycle)
//   bus      : stream in + RAM write port (matrix_loader_if.slave)
//   busy     : load in progress
//   done     : one-cycle pulse after the final RAM write
//   err      : sticky zero-on-diagonal flag
// Build option: define MATRIX_LOADER_ZERO_PIVOT_CHK_EN to build the zero-pivot
// check; otherwise err is tied low.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int N         = MAT_N,
    parameter int DATA_W    = MAT_DATA_W,
    parameter int ADDR_W    = MAT_ADDR_W,
    parameter int BASE_ADDR = MAT_BASE_ADDR,
    parameter logic [DATA_W-1:0] ONE_VAL = MAT_ONE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    matrix_loader_if.slave   bus,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int ROW_W = idx_w(N);
    localparam int COL_W = idx_w(2 * N);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_LOAD_A = LOAD_A;
    localparam logic [1:0] ST_GEN_I  = GEN_I;

    logic [1:0]        state;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] addr;
    logic              last_a_col, last_col, last_row;
    logic              accept, hs, gen, id_diag;

    // done is high in the first IDLE cycle; a start there is dropped.
    assign accept       = (state == ST_IDLE) && start && !done;
    assign hs           = (state == ST_LOAD_A) && bus.in_valid;
    assign gen          = (state == ST_GEN_I);
    assign bus.in_ready = (state == ST_LOAD_A);
    assign id_diag      = (int'(col) == int'(row) + N);

    matrix_index_counter #(
        .N         (N),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_idx (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .advance    (hs | gen),
        .row        (row),
        .col        (col),
        .addr       (addr),
        .last_a_col (last_a_col),
        .last_col   (last_col),
        .last_row   (last_row)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= ADDR_W'(BASE_ADDR);
            bus.ram_din  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            bus.ram_we <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_LOAD_A;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD_A: begin
                    if (bus.in_valid) begin
                        bus.ram_we   <= 1'b1;
                        bus.ram_addr <= addr;
                        bus.ram_din  <= bus.in_data;
                        if (last_a_col) state <= ST_GEN_I;
                    end
                end
                ST_GEN_I: begin
                    bus.ram_we   <= 1'b1;
                    bus.ram_addr <= addr;
                    bus.ram_din  <= id_diag ? ONE_VAL : '0;
                    if (last_col) state <= last_row ? FIN : ST_LOAD_A;
                end
                default: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MATRIX_LOADER_ZERO_PIVOT_CHK_EN
    // In LOAD_A col < N, so col == row is exactly the diagonal of A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                              err <= 1'b0;
        else if (accept)                                      err <= 1'b0;
        else if (hs && int'(col) == int'(row) && bus.in_data == '0) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_loader.sv
module tb_matrix_loader;
    import matrix_pkg::*;

    localparam int N  = MAT_N;
    localparam int NW = 2 * N * N;
    localparam int U1_BASE = 10;
    localparam logic [31:0] U1_ONE = 32'h3F800000;
`ifdef MATRIX_LOADER_ZERO_PIVOT_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int mode;        // 0: valid held high, 1: valid toggles, 2: random valid
        int restart_at;  // pulse start again after this many writes (0: never)
        bit zero22;      // force A[2][2] = 0
        bit sod;         // drive start in the done cycle
        int exp_writes;
        int exp_dones;
        bit exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic busy0, done0, err0, busy1, done1, err1;

    int nchk = 0;
    int nfail = 0;

    logic [31:0] A [N*N];
    int          base [2] = '{MAT_BASE_ADDR, U1_BASE};
    logic [31:0] one  [2] = '{MAT_ONE, U1_ONE};
    bit mon_en = 1'b0;
    int nwr [2];
    int ndone [2];
    bit prev_rdy [2];
    bit prev_vld [2];
    bit prev_we [2];
    int prev_addr [2];
    bit errm [2];

    matrix_loader_if b0 ();
    matrix_loader_if b1 ();
    assign b0.in_valid = in_valid;
    assign b0.in_data  = in_data;
    assign b1.in_valid = in_valid;
    assign b1.in_data  = in_data;

    matrix_loader u0 (
        .clk(clk), .rst(rst), .start(start), .bus(b0),
        .busy(busy0), .done(done0), .err(err0)
    );

    matrix_loader #(.BASE_ADDR(U1_BASE), .ONE_VAL(U1_ONE)) u1 (
        .clk(clk), .rst(rst), .start(start), .bus(b1),
        .busy(busy1), .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected RAM word for the i-th write of a load: [A | I] row-major.
    function automatic logic [31:0] exp_word(input int d, input int i);
        int r, c;
        r = i / (2 * N);
        c = i % (2 * N);
        if (c < N) return A[r*N + c];
        return (c - N == r) ? one[d] : 32'd0;
    endfunction

    task automatic mon_dut(input int d, input logic we, input logic [MAT_ADDR_W-1:0] addr,
                           input logic [31:0] din, input logic rdy, input logic vld,
                           input logic dn, input logic bsy, input logic er);
        int i, c, r;
        // a cycle offering in_ready writes next cycle iff in_valid was high
        if (prev_rdy[d]) chk("we_iff_handshake", we, prev_vld[d]);
        if (we) begin
            i = nwr[d];
            if (i < NW) begin
                r = i / (2 * N);
                c = i % (2 * N);
                chk("addr", addr, base[d] + i);
                chk("data", din, exp_word(d, i));
                if (c >= N) chk("ready_low_in_gen", prev_rdy[d], 0);
                else if (c == r && A[r*N + c] == 0 && CHK) errm[d] = 1'b1;
                chk("err_track", er, errm[d]);
            end
            nwr[d]++;
        end
        if (dn) begin
            ndone[d]++;
            chk("done_after_last", (prev_we[d] && prev_addr[d] == base[d] + NW - 1), 1);
            chk("busy_low_at_done", bsy, 0);
            chk("err_at_done", er, errm[d]);
        end
        prev_rdy[d]  = rdy;
        prev_vld[d]  = vld;
        prev_we[d]   = we;
        prev_addr[d] = int'(addr);
    endtask

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            mon_dut(0, b0.ram_we, b0.ram_addr, b0.ram_din, b0.in_ready, in_valid, done0, busy0, err0);
            mon_dut(1, b1.ram_we, b1.ram_addr, b1.ram_din, b1.in_ready, in_valid, done1, busy1, err1);
        end
    end

    // Entered and left just after a rising edge.
    task automatic run_load(input vec_t v);
        int idx, cyc, extra;
        bit tog, restarted, hs;
        idx = 0; cyc = 0; extra = 0; tog = 1'b1; restarted = 1'b0;
        for (int i = 0; i < N*N; i++) begin
            A[i] = (v.mode < 2) ? 32'(i + 1) : $urandom;
            if (A[i] == 0) A[i] = 32'd1;
        end
        if (v.zero22) A[2*N + 2] = '0;
        for (int d = 0; d < 2; d++) begin
            nwr[d] = 0; ndone[d] = 0; prev_rdy[d] = 0; prev_vld[d] = 0;
            prev_we[d] = 0; prev_addr[d] = 0; errm[d] = 0;
        end
        mon_en = 1'b1;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (cyc < 400 && extra < 4) begin
            if (ndone[0] > 0) extra++;
            if (v.restart_at != 0 && !restarted && nwr[0] >= v.restart_at) begin
                start = 1'b1;
                restarted = 1'b1;
            end else begin
                start = 1'b0;
            end
            case (v.mode)
                0:       in_valid = 1'b1;
                1:       in_valid = tog;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            tog = ~tog;
            if (idx >= N*N) in_valid = 1'b0;
            in_data = (idx < N*N) ? A[idx] : $urandom;
            @(negedge clk);
            if (cyc == 0) begin
                chk("busy_after_start", busy0, 1);
                chk("err_cleared_by_start", err0, 0);
            end
            hs = in_valid && b0.in_ready;
            if (v.sod && done0) start = 1'b1;
            @(posedge clk); #1;
            if (hs) idx++;
            cyc++;
        end
        mon_en = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        chk("writes_u0", nwr[0], v.exp_writes);
        chk("writes_u1", nwr[1], v.exp_writes);
        chk("dones_u0", ndone[0], v.exp_dones);
        chk("dones_u1", ndone[1], v.exp_dones);
        chk("words_consumed", idx, N*N);
        chk("idle_after_u0", busy0, 0);
        chk("idle_after_u1", busy1, 0);
        chk("err_final_u0", err0, v.exp_err);
        chk("err_final_u1", err1, v.exp_err);
    endtask

    initial begin
        vec_t tbl [6];
        int idx, cnt, dn;
        bit hs;
        tbl[0] = '{mode:0, restart_at:0,  zero22:0, sod:0, exp_writes:NW, exp_dones:1, exp_err:0};
        tbl[1] = '{mode:1, restart_at:0,  zero22:0, sod:0, exp_writes:NW, exp_dones:1, exp_err:0};
        tbl[2] = '{mode:0, restart_at:10, zero22:0, sod:0, exp_writes:NW, exp_dones:1, exp_err:0};
        tbl[3] = '{mode:2, restart_at:0,  zero22:1, sod:0, exp_writes:NW, exp_dones:1, exp_err:CHK};
        tbl[4] = '{mode:2, restart_at:0,  zero22:0, sod:1, exp_writes:NW, exp_dones:1, exp_err:0};
        tbl[5] = '{mode:2, restart_at:37, zero22:0, sod:0, exp_writes:NW, exp_dones:1, exp_err:0};

        repeat (2) @(negedge clk);
        chk("rst_we_u0", b0.ram_we, 0);
        chk("rst_addr_u0", b0.ram_addr, MAT_BASE_ADDR);
        chk("rst_din_u0", b0.ram_din, 0);
        chk("rst_ready_u0", b0.in_ready, 0);
        chk("rst_busy_u0", busy0, 0);
        chk("rst_done_u0", done0, 0);
        chk("rst_err_u0", err0, 0);
        chk("rst_addr_u1", b1.ram_addr, U1_BASE);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 6; t++) run_load(tbl[t]);

        // Reset in the cycle the 23rd write is presented: abort, no done.
        for (int i = 0; i < N*N; i++) A[i] = 32'(i + 1);
        idx = 0; cnt = 0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && cnt < 23; k++) begin
            in_data = (idx < N*N) ? A[idx] : 32'd0;
            @(negedge clk);
            if (b0.ram_we) cnt++;
            hs = b0.in_ready;
            if (cnt < 23) begin
                @(posedge clk); #1;
                if (hs) idx++;
            end
        end
        chk("abort_reached_23", cnt, 23);
        rst = 1'b1;
        #1;
        chk("abort_we_u0", b0.ram_we, 0);
        chk("abort_we_u1", b1.ram_we, 0);
        chk("abort_ready", b0.in_ready, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_addr", b0.ram_addr, MAT_BASE_ADDR);
        in_valid = 1'b0;
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0 || done1) dn++;
        end
        chk("abort_no_done", dn, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        run_load(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
